// File: rtl/nr_div_seq.sv
// Signed Q48.16 Newton-Raphson divider built around one shared 64x32 multiplier.
// Latency: out_valid rises 2*ITER+5 edges after acceptance, 1 edge after it for divide-by-zero.
// Backpressure: result held in DONE until out_ready; in_ready low whenever busy.
// Build option: define NR_DIV_SAT_EN to saturate the quotient on overflow / divide-by-zero.
module nr_div_seq #(
  parameter int ITER = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] numerator,
  input  logic [63:0] denominator,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] quotient,
  output logic        dz,
  output logic        ovf
);

  // Seed line x0 = 48/17 - 32/17*m, both constants in Q2.30
  localparam logic [31:0] C1 = 32'd3031741621;
  localparam logic [31:0] C2 = 32'd2021161080;

`ifdef NR_DIV_SAT_EN
  localparam logic [63:0] Q_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Q_MIN = 64'h8000_0000_0000_0000;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_NORM, S_SEED, S_MDX, S_MXE, S_MNX, S_SCALE, S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  iter_cnt;
  logic        sn, sd;
  logic [63:0] na, da;
  logic [5:0]  p;
  logic [31:0] m;      // normalized |d|, Q0.32 in [0.5,1)
  logic [31:0] x;      // reciprocal estimate of m, Q2.30
  logic [31:0] t;      // m*x, Q2.30
  logic [95:0] prod;   // na*x
  logic [95:0] r;      // unsigned quotient magnitude, Q48.16
  logic        scale_ph;

  logic [5:0]  lead_p;
  logic [31:0] m_c;
  logic [31:0] e_c;
  logic [63:0] mul_a;
  logic [31:0] mul_b;
  logic [95:0] mul_p;
  logic [95:0] sh_r;
  logic        neg;
  logic        ovf_c;
  logic [63:0] mag_q;
  logic [63:0] q_c;
  logic [63:0] dzq;

  // Leading-one position of |d| and the normalized mantissa derived from it
  always_comb begin
    lead_p = '0;
    for (int i = 0; i < 64; i++) begin
      if (da[i]) lead_p = 6'(i);
    end
    m_c = 32'((da << (6'd63 - lead_p)) >> 32);
  end

  assign e_c  = 32'h8000_0000 - t;
  assign sh_r = prod >> ({1'b0, p} + 7'd15);

  // Operand select for the single shared multiplier, one product per cycle
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_SEED: begin mul_a = {32'd0, m}; mul_b = C2;  end
      S_MDX:  begin mul_a = {32'd0, m}; mul_b = x;   end
      S_MXE:  begin mul_a = {32'd0, x}; mul_b = e_c; end
      S_MNX:  begin mul_a = na;         mul_b = x;   end
      default: ;
    endcase
  end

  assign mul_p = {32'd0, mul_a} * {64'd0, mul_b};

  // Final sign, overflow and (optionally saturated) quotient from the magnitude
  always_comb begin
    neg   = sn ^ sd;
    ovf_c = (|r[95:63]) && !(neg && (r == 96'h8000_0000_0000_0000));
    mag_q = neg ? (64'd0 - r[63:0]) : r[63:0];
    q_c   = mag_q;
    dzq   = '0;
`ifdef NR_DIV_SAT_EN
    if (ovf_c) q_c = neg ? Q_MIN : Q_MAX;
    if (na != 64'd0) dzq = sn ? Q_MIN : Q_MAX;
`endif
  end

  // Sequencer: operand capture, normalize, seed, ITER refinements, scale, hold result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      iter_cnt  <= '0;
      sn        <= 1'b0;
      sd        <= 1'b0;
      na        <= '0;
      da        <= '0;
      p         <= '0;
      m         <= '0;
      x         <= '0;
      t         <= '0;
      prod      <= '0;
      r         <= '0;
      scale_ph  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sn       <= numerator[63];
            sd       <= denominator[63];
            na       <= numerator[63] ? (64'd0 - numerator) : numerator;
            da       <= denominator[63] ? (64'd0 - denominator) : denominator;
            iter_cnt <= '0;
            in_ready <= 1'b0;
            state    <= S_NORM;
          end
        end
        S_NORM: begin
          // Zero divisor is detected on the captured magnitude and skips straight to DONE
          if (da == 64'd0) begin
            quotient  <= dzq;
            dz        <= 1'b1;
            ovf       <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            p     <= lead_p;
            m     <= m_c;
            state <= S_SEED;
          end
        end
        S_SEED: begin
          x     <= C1 - mul_p[63:32];
          state <= S_MDX;
        end
        S_MDX: begin
          t     <= mul_p[63:32];
          state <= S_MXE;
        end
        S_MXE: begin
          x        <= mul_p[61:30];
          iter_cnt <= iter_cnt + 3'd1;
          state    <= (iter_cnt == 3'(ITER - 1)) ? S_MNX : S_MDX;
        end
        S_MNX: begin
          prod     <= mul_p;
          scale_ph <= 1'b0;
          state    <= S_SCALE;
        end
        S_SCALE: begin
          // Variable shift is registered first, sign/overflow resolved the cycle after
          if (!scale_ph) begin
            r        <= sh_r;
            scale_ph <= 1'b1;
          end else begin
            quotient  <= q_c;
            dz        <= 1'b0;
            ovf       <= ovf_c;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nr_div_seq.sv
// Bench for nr_div_seq: directed and random divides against an exact floor-division model.
// Latency: measured per operation in edges from acceptance.
// Backpressure: exercised by holding out_ready low while in_valid is driven with junk.
module tb_nr_div_seq;

  localparam int ITER = 3;
  localparam logic signed [127:0] MAXQ = 128'sd9223372036854775807;
  localparam logic signed [127:0] MINQ = -MAXQ - 128'sd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] numerator = '0;
  logic [63:0] denominator = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] quotient;
  logic        dz;
  logic        ovf;

  int total = 0;
  int bad = 0;

  nr_div_seq #(.ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .numerator(numerator), .denominator(denominator),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp, input int tol);
    longint diff;
    diff = longint'(got - exp);
    if (diff < 0) diff = -diff;
    total++;
    if (diff > longint'(tol)) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Exact floor(n*2^16/d) in wide signed arithmetic
  function automatic logic signed [127:0] ref_div(input logic [63:0] n, input logic [63:0] d);
    logic signed [127:0] num, den, q, rm;
    num = {{48{n[63]}}, n, 16'd0};
    den = {{64{d[63]}}, d};
    q   = num / den;
    rm  = num % den;
    if (rm != 0 && (num[127] != den[127])) q = q - 128'sd1;
    return q;
  endfunction

  task automatic run_op(input string tag, input logic [63:0] n, input logic [63:0] d,
                        input int hold, input bit junk);
    logic signed [127:0] rq;
    logic [63:0] eq;
    logic edz, eovf, chkq;
    int etol, elat, w, lat;
    edz  = (d == 64'd0);
    eovf = 1'b0;
    chkq = 1'b1;
    etol = 0;
    eq   = '0;
    elat = edz ? 1 : 2 * ITER + 5;
    if (edz) begin
`ifdef NR_DIV_SAT_EN
      eq = (n == 64'd0) ? 64'd0 : (n[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF);
`else
      eq = 64'd0;
`endif
    end else begin
      rq   = ref_div(n, d);
      eovf = (rq > MAXQ) || (rq < MINQ);
      if (eovf) begin
`ifdef NR_DIV_SAT_EN
        eq = (rq < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`else
        chkq = 1'b0;
`endif
      end else begin
        eq   = rq[63:0];
        etol = 2;
      end
    end

    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, ".idle"}, 64'(in_ready), 64'd1, 0);
    numerator   = n;
    denominator = d;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".busy"}, 64'(in_ready), 64'd0, 0);

    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(elat), 0);
    if (chkq) chk({tag, ".q"}, quotient, eq, etol);
    chk({tag, ".dz"}, 64'(dz), 64'(edz), 0);
    chk({tag, ".ovf"}, 64'(ovf), 64'(eovf), 0);

    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        in_valid    = 1'b1;
        numerator   = {$urandom, $urandom};
        denominator = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      if (junk) begin
        if (chkq) chk({tag, ".hold_q"}, quotient, eq, etol);
        chk({tag, ".hold_rdy"}, 64'(in_ready), 64'd0, 0);
        chk({tag, ".hold_vld"}, 64'(out_valid), 64'd1, 0);
      end
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, ".taken_vld"}, 64'(out_valid), 64'd0, 0);
    chk({tag, ".taken_rdy"}, 64'(in_ready), 64'd1, 0);
  endtask

  initial begin
    int seen;
    int wd, wn;
    logic [63:0] rn, rd;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1, 0);
    chk("rst.out_valid", 64'(out_valid), 64'd0, 0);
    chk("rst.quotient", quotient, 64'd0, 0);
    chk("rst.dz", 64'(dz), 64'd0, 0);
    chk("rst.ovf", 64'(ovf), 64'd0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("basic", 64'd655360, 64'd131072, 0, 0);
    run_op("neg_d", 64'd655360, 64'hFFFF_FFFF_FFFC_0000, 0, 0);
    run_op("neg_nd", 64'hFFFF_FFFF_FFF6_0000, 64'hFFFF_FFFF_FFFC_0000, 0, 0);
    run_op("dz_pos", 64'd655360, 64'd0, 0, 0);
    run_op("dz_neg", 64'hFFFF_FFFF_FFF6_0000, 64'd0, 0, 0);
    run_op("dz_zero", 64'd0, 64'd0, 0, 0);
    run_op("ovf_pos", 64'h7FFF_0000_0000_0000, 64'd1, 0, 0);
    run_op("ovf_neg", 64'h7FFF_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    run_op("min_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0);
    run_op("zero_n", 64'd0, 64'd12345, 0, 0);

    run_op("bp", 64'd655360, 64'd131072, 20, 1);
    run_op("after_bp", 64'd196608, 64'd98304, 0, 0);

    numerator   = 64'd655360;
    denominator = 64'd131072;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("midrst.busy", 64'(in_ready), 64'd0, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0, 0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst.no_result", 64'(seen), 64'd0, 0);
    run_op("post_rst", 64'd655360, 64'd131072, 0, 0);

    for (int i = 0; i < 40; i++) begin
      wd = int'($urandom_range(1, 62));
      wn = int'($urandom_range(0, (wd + 6 > 62) ? 62 : wd + 6));
      rd = ({$urandom, $urandom} & ((64'd1 << wd) - 64'd1)) | (64'd1 << (wd - 1));
      rn = (wn == 0) ? 64'd0 : ({$urandom, $urandom} & ((64'd1 << wn) - 64'd1));
      if ($urandom_range(0, 1) == 1) rd = 64'd0 - rd;
      if ($urandom_range(0, 1) == 1) rn = 64'd0 - rn;
      if (i % 10 == 9) rd = 64'd0;
      run_op($sformatf("rnd%0d", i), rn, rd, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
